// File: rtl/ram_rd_pkg.sv
// ============================================================================
// Module  : ram_rd_pkg
// Brief   : Shared types, constants and read-credit helper for ram_burst_reader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_rd_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

  localparam int RD_BUF_DEPTH = 2;

  // A new read may only be launched if its data is guaranteed a buffer slot.
  function automatic logic rd_can_issue(
    input logic [1:0] buffered,
    input logic       in_flight,
    input logic       pop
  );
    logic [2:0] total;
    total = {1'b0, buffered} + {2'b00, in_flight};
    return (total <= 3'd1) || pop;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_rd_skid_buf.sv
// ============================================================================
// Module  : ram_rd_skid_buf
// Brief   : Two-entry FIFO with push input, valid/ready output and occupancy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_rd_skid_buf
  import ram_rd_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [RD_BUF_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_push;

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign w_pop   = o_valid && i_ready;
  // The issuer's credit check already prevents overflow; this guard only protects storage.
  assign w_push  = i_push && ((r_count != 2'(RD_BUF_DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_burst_reader.sv
// ============================================================================
// Module  : ram_burst_reader
// Brief   : Burst read master for RAM port B with valid/ready output stream.
//           Optional running XOR checksum enabled by RAM_RD_CHECKSUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_burst_reader
  import ram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef RAM_RD_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  rd_state_t             r_state;
  rd_state_t             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_done;
  logic                  w_issue;
  logic                  w_last_issue;
  logic                  w_done_nxt;
  logic                  w_pop;
  logic                  w_start_accept;
  logic                  w_buf_valid;
  logic [DATA_WIDTH:0]   w_buf_data;
  logic [1:0]            w_buf_count;

  assign w_start_accept = (r_state == RD_IDLE) && start;
  assign w_pop          = w_buf_valid && m_ready;
  assign w_last_issue   = w_issue && (r_remaining == LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_state_nxt = RD_READ;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      RD_READ: begin
        w_issue = rd_can_issue(w_buf_count, r_inflight, w_pop);
        if (w_issue && (r_remaining == LEN_WIDTH'(1))) begin
          w_state_nxt = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (w_pop && m_last) begin
          w_state_nxt = RD_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // The issued address goes straight to the RAM so its data lands one edge later.
  assign addr_b = w_issue ? r_next_addr : r_addr_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_addr     <= '0;
      r_addr_hold     <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      if (w_start_accept) begin
        r_next_addr <= base_addr;
        r_remaining <= len;
      end else if (w_issue) begin
        r_addr_hold <= r_next_addr;
        r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - LEN_WIDTH'(1);
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;
      r_done          <= w_done_nxt;
    end
  end

  ram_rd_skid_buf #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_last, rdata_b}),
    .o_valid (w_buf_valid),
    .i_ready (m_ready),
    .o_data  (w_buf_data),
    .o_count (w_buf_count)
  );

  assign m_valid = w_buf_valid;
  assign m_data  = w_buf_data[DATA_WIDTH-1:0];
  assign m_last  = w_buf_data[DATA_WIDTH];
  assign busy    = (r_state != RD_IDLE);
  assign done    = r_done;

`ifdef RAM_RD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_start_accept) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum ^ m_data;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
// ============================================================================
// Module  : tb_ram_burst_reader
// Brief   : Scoreboard bench for ram_burst_reader with a registered-read RAM model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] len = '0;
  logic       busy;
  logic       done;
  logic [7:0] addr_b;
  logic [7:0] rdata_b = '0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_last;
`ifdef RAM_RD_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_hs    = 0;

  logic [7:0] mem [256];
  logic [8:0] sb [$];

  logic       prev_stall = 1'b0;
  logic [7:0] stall_data = '0;
  logic       stall_last = 1'b0;

  ram_burst_reader #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8),
    .LEN_WIDTH  (9)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .addr_b    (addr_b),
    .rdata_b   (rdata_b),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
`ifdef RAM_RD_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  // RAM port B: one-cycle registered read
  always @(posedge clk) rdata_b <= mem[addr_b];

  // Output monitor: pops the scoreboard on each handshake and checks stall stability
  always @(negedge clk) begin
    logic [8:0] exp_beat;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_tests++;
        if (!m_valid || m_data !== stall_data || m_last !== stall_last) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%0b data=%02h last=%0b, required valid=1 data=%02h last=%0b",
                   m_valid, m_data, m_last, stall_data, stall_last);
        end
      end
      if (m_valid && m_ready) begin
        n_hs++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got data=%02h last=%0b, required no beat", m_data, m_last);
        end else begin
          exp_beat = sb.pop_front();
          if ({m_last, m_data} !== exp_beat) begin
            n_fail++;
            $display("FAIL beat_data: got data=%02h last=%0b, required data=%02h last=%0b",
                     m_data, m_last, exp_beat[7:0], exp_beat[8]);
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
    end
  end

  task automatic push_expected(input logic [7:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] a;
      a = b + 8'(k);
      sb.push_back({(k == n - 1), mem[a]});
    end
  endtask

  // Drives a one-cycle start; returns #1 after the sampling edge E0
  task automatic do_start(input logic [7:0] b, input logic [8:0] n);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    len       = n;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, addr_b, m_valid, m_data, m_last} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_values: got busy=%0b done=%0b addr_b=%02h valid=%0b data=%02h last=%0b, required all 0",
               busy, done, addr_b, m_valid, m_data, m_last);
    end
`ifdef RAM_RD_CHECKSUM_EN
    n_tests++;
    if (checksum !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_checksum: got %02h, required 00", checksum);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    push_expected(8'h10, 4);
    do_start(8'h10, 9'd4);
    n_tests++;
    if (busy !== 1'b1 || m_valid !== 1'b0 || addr_b !== 8'h10) begin
      n_fail++;
      $display("FAIL basic_e0: got busy=%0b valid=%0b addr_b=%02h, required busy=1 valid=0 addr_b=10",
               busy, m_valid, addr_b);
    end
    @(posedge clk); #1;
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency_e1: got valid=%0b, required 0", m_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 8'hA0) begin
      n_fail++;
      $display("FAIL basic_first_beat: got valid=%0b data=%02h, required valid=1 data=A0", m_valid, m_data);
    end
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got done=%0b busy=%0b valid=%0b, required done=1 busy=0 valid=0",
               done, busy, m_valid);
    end
`ifdef RAM_RD_CHECKSUM_EN
    n_tests++;
    if (checksum !== (8'hA0 ^ 8'hA1 ^ 8'hA2 ^ 8'hA3)) begin
      n_fail++;
      $display("FAIL basic_checksum: got %02h, required %02h", checksum, 8'hA0 ^ 8'hA1 ^ 8'hA2 ^ 8'hA3);
    end
`endif
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: got done=%0b pending=%0d, required done=0 pending=0", done, sb.size());
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_addr [4];
    bit ok;
    exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    m_ready = 1'b1;
    push_expected(8'hFE, 4);
    do_start(8'hFE, 9'd4);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (addr_b !== exp_addr[i]) begin
        n_fail++;
        $display("FAIL wrap_addr[%0d]: got %02h, required %02h", i, addr_b, exp_addr[i]);
      end
      @(posedge clk); #1;
    end
    wait_idle(20, ok);
    n_tests++;
    if (!ok || sb.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_complete: got idle=%0b pending=%0d, required idle=1 pending=0", ok, sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic pat [6];
    int   hs0;
    int   cyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    hs0 = n_hs;
    m_ready = 1'b1;
    push_expected(8'h20, 8);
    do_start(8'h20, 9'd8);
    cyc = 0;
    while (busy && cyc < 100) begin
      m_ready = pat[cyc % 6];
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b1;
    n_tests++;
    if (busy || (n_hs - hs0) != 8 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL backpressure_count: got busy=%0b handshakes=%0d pending=%0d, required busy=0 handshakes=8 pending=0",
               busy, n_hs - hs0, sb.size());
    end
  endtask

  task automatic test_zero_len_and_busy();
    int hs0;
    bit ok;
    hs0 = n_hs;
    m_ready = 1'b1;
    do_start(8'h00, 9'd0);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_done: got done=%0b busy=%0b valid=%0b, required done=1 busy=0 valid=0",
               done, busy, m_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || (n_hs - hs0) != 0) begin
      n_fail++;
      $display("FAIL zero_len_after: got done=%0b busy=%0b beats=%0d, required 0 0 0", done, busy, n_hs - hs0);
    end
    push_expected(8'h30, 3);
    do_start(8'h30, 9'd3);
    start     = 1'b1;
    base_addr = 8'h40;
    len       = 9'd5;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(30, ok);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (!ok || busy || (n_hs - hs0) != 3 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got idle=%0b beats=%0d pending=%0d, required idle=1 beats=3 pending=0",
               ok, n_hs - hs0, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    m_ready = 1'b1;
    push_expected(8'h50, 6);
    do_start(8'h50, 9'd6);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, addr_b, m_valid, m_data, m_last} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid_values: got busy=%0b done=%0b addr_b=%02h valid=%0b data=%02h last=%0b, required all 0",
               busy, done, addr_b, m_valid, m_data, m_last);
    end
    n_tests++;
    if (sb.size() != 4) begin
      n_fail++;
      $display("FAIL reset_mid_progress: got %0d beats pending, required 4", sb.size());
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_expected(8'h60, 3);
    do_start(8'h60, 9'd3);
    wait_idle(30, ok);
    n_tests++;
    if (!ok || sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_rerun: got idle=%0b pending=%0d, required idle=1 pending=0", ok, sb.size());
    end
  endtask

  task automatic test_full_memory();
    int hs0;
    int cyc;
    hs0 = n_hs;
    m_ready = 1'b1;
    push_expected(8'h00, 256);
    do_start(8'h00, 9'd256);
    cyc = 0;
    while (busy && cyc < 3000) begin
      m_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b1;
    n_tests++;
    if (busy || (n_hs - hs0) != 256 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL full_memory: got busy=%0b beats=%0d pending=%0d, required busy=0 beats=256 pending=0",
               busy, n_hs - hs0, sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'hC3;
    end
    mem[8'h10] = 8'hA0;
    mem[8'h11] = 8'hA1;
    mem[8'h12] = 8'hA2;
    mem[8'h13] = 8'hA3;

    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len_and_busy();
    test_reset_mid();
    test_full_memory();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side master for the dual-port RAM: accepts a burst command (base address, beat count), drives the RAM read port (`addr_b`), absorbs the RAM's one-cycle registered read latency, and streams the words out on a valid/ready interface with full backpressure. It sits between the RAM's port B and any downstream consumer, and complements the port-A writer. Sustains one beat per cycle when `m_ready` is held high.

## Interface
- `ADDR_WIDTH`, default 8: RAM address width; must match the RAM.
- `DATA_WIDTH`, default 8: RAM data width; must match the RAM.
- `LEN_WIDTH`, default `ADDR_WIDTH+1`: width of the beat count, so a full-memory burst is expressible.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: command strobe, sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: first read address.
- `len` in LEN_WIDTH: number of beats.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse at burst completion.
- `addr_b` out ADDR_WIDTH: RAM port B address.
- `rdata_b` in DATA_WIDTH: RAM port B read data, valid one cycle after its address.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: consumer accepts the beat.
- `m_data` out DATA_WIDTH: output beat.
- `m_last` out 1: marks the final beat of the burst.
- `checksum` out DATA_WIDTH: running XOR of the words accepted in the current burst. Present only with `RAM_RD_CHECKSUM_EN`.

## Operation
- **States.**
  - IDLE: `start && len!=0` -> READ. `start && len==0` -> stays IDLE and pulses `done` in the next cycle.
  - READ: issues reads. When the last address has been issued -> DRAIN.
  - DRAIN: waits for in-flight and buffered beats to be accepted. When the last beat handshakes (`m_valid && m_ready && m_last`) -> IDLE, and `done` pulses for one cycle.
- **Outstanding tracking.** The buffer is 2 entries deep. A read is issued in a cycle only if `buffered + in_flight <= 1`, or if a pop (`m_valid && m_ready`) occurs in the same cycle. This prevents overflow, so no read is ever lost.
- **Address generation.** The address starts at `base_addr` and increments by 1 per issued read. It wraps modulo 2^ADDR_WIDTH (for example, 0xFF -> 0x00 at the default width). A read is issued `len` times in total.
- **Output rules.**
  - Beats come out in address order.
  - `m_data` and `m_last` hold stable while `m_valid && !m_ready`.
  - `m_last` is asserted only together with the `len`-th beat.
- **Ignored inputs.** `start` in READ or DRAIN is ignored. The command is not queued.
- **Driving `addr_b`.** `addr_b` holds its last value when no read is issued. Redundant reads are harmless because their data is not captured.
- **Reset.** Asserting reset at any time, including mid-burst, returns the block to IDLE, empties the buffer and discards in-flight reads.
- **Reset values.** `busy`=0, `done`=0, `addr_b`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `checksum`=0.

## Timing
- `start` is sampled at edge E0. `busy` goes high after E0.
- `addr_b`=`base_addr` during the cycle E0–E1. The RAM registers it at E1, the buffer captures `rdata_b` at E2, and `m_valid` goes high after E2.
- With `m_ready` held high, there is one beat per cycle and no bubbles.
- `busy` falls and `done` rises on the edge where the last beat handshakes. `done` is high for exactly one cycle.
- A new `start` is accepted in the cycle `done` is high; the block is already in IDLE then.

## Configuration
- `RAM_RD_CHECKSUM_EN` defined:
  - `checksum` port exists.
  - It is cleared on accepted `start`.
  - It is XORed with `m_data` on every handshake.
  - It holds its value after `done` until the next start.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `ram_rd_pkg`:
  - state enum typedef (`RD_IDLE`, `RD_READ`, `RD_DRAIN`);
  - constant `RD_BUF_DEPTH`=2;
  - the credit-check helper function.
- Sub-module `ram_rd_skid_buf`: a 2-entry FIFO with valid/ready output, count output and a `push` input, parameterised by DATA_WIDTH plus 1 bit for `last`.

## Test plan
- **Basic burst.** Preload RAM[0x10..0x13]=A0,A1,A2,A3. Issue start base=0x10, len=4 with `m_ready`=1. Required: `m_valid` first high 2 edges after start; beats A0..A3 on consecutive cycles; `m_last` on A3; `done` one cycle; checksum=A0^A1^A2^A3.
- **Address wrap.** Issue start base=0xFE, len=4. Required: `addr_b` sequence FE, FF, 00, 01, with data returned in that order.
- **Backpressure.** Toggle `m_ready` 1,0,0,1,0,1 during an 8-beat burst. Required: no beat lost or duplicated; `m_data` stable while stalled; exactly 8 handshakes.
- **Zero length and busy.** `len`=0 -> `done` after 1 cycle, `busy` stays 0, no `m_valid`. A `start` while `busy` -> ignored, with the beat count unchanged.
- **Reset mid-burst.** Assert `rst_n`=0 after 2 of 6 beats. Required: all outputs at reset values immediately. A new burst after release returns correct data, with no stale beats.
- **Full memory.** Issue `len`=256, base=0. Required: 256 beats, and `m_last` only on the beat read from address 0xFF.
